// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared shape constants, shape type and queue FSM state
package tetris_pkg;
  localparam int SHAPE_W = 3;
  localparam logic [SHAPE_W-1:0] SHAPE_INVALID = 3'd7;
  // Wide enough for a count of 0..8 entries.
  localparam int CNT_W = 4;

  typedef logic [SHAPE_W-1:0] shape_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;
endpackage

// File: rtl/piece_fifo.sv
// rtl/piece_fifo.sv - circular shape buffer with registered head/preview outputs
module piece_fifo
  import tetris_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               push,
  input  logic               pop,
  input  logic [SHAPE_W-1:0] din,
  output logic [CNT_W-1:0]   count,
  output logic [SHAPE_W-1:0] head,
  output logic               head_valid,
  output logic [SHAPE_W-1:0] preview,
  output logic               preview_valid
);
  localparam int PW = $clog2(DEPTH);

  shape_t            mem   [DEPTH];
  shape_t            mem_n [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_n, wr_n;
  logic [CNT_W-1:0]  cnt_n;
  shape_t            head_n, preview_n;
  logic              hv_n, pv_n;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Head/preview are looked up from the post-update state so they register in step with it.
  always_comb begin
    mem_n = mem;
    rd_n  = rd_ptr;
    wr_n  = wr_ptr;
    if (push) begin
      mem_n[wr_ptr] = din;
      wr_n          = inc(wr_ptr);
    end
    if (pop) rd_n = inc(rd_ptr);
    cnt_n     = count + CNT_W'(push) - CNT_W'(pop);
    hv_n      = (cnt_n != '0);
    pv_n      = (cnt_n >= CNT_W'(2));
    head_n    = hv_n ? mem_n[rd_n] : '0;
    preview_n = pv_n ? mem_n[inc(rd_n)] : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      head          <= '0;
      head_valid    <= 1'b0;
      preview       <= '0;
      preview_valid <= 1'b0;
    end else begin
      mem           <= mem_n;
      rd_ptr        <= rd_n;
      wr_ptr        <= wr_n;
      count         <= cnt_n;
      head          <= head_n;
      head_valid    <= hv_n;
      preview       <= preview_n;
      preview_valid <= pv_n;
    end
  end
endmodule

// File: rtl/piece_queue.sv
// rtl/piece_queue.sv - filtered upcoming-piece queue with drop counter and FILL/FULL FSM
// Optional PIECE_NO_REPEAT_EN: also reject a sample equal to the last pushed shape.
module piece_queue
  import tetris_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [SHAPE_W-1:0] rand_id,
  input  logic               take,
  output logic [SHAPE_W-1:0] piece_id,
  output logic               piece_valid,
  output logic [SHAPE_W-1:0] preview_id,
  output logic               preview_valid,
  output logic [7:0]         drop_cnt
);
  state_t           state, state_n;
  logic [CNT_W-1:0] count;
  logic             full, accept, push, pop;

  assign full = (state == FULL);
  assign pop  = resetn && take && piece_valid;
  assign push = resetn && accept && (!full || pop);

`ifdef PIECE_NO_REPEAT_EN
  shape_t last_id;
  logic   last_valid;

  assign accept = (rand_id != SHAPE_INVALID) && !(last_valid && rand_id == last_id);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_id    <= '0;
      last_valid <= 1'b0;
    end else if (push) begin
      last_id    <= rand_id;
      last_valid <= 1'b1;
    end
  end
`else
  assign accept = (rand_id != SHAPE_INVALID);
`endif

  always_comb begin
    state_n = state;
    case (state)
      FILL: if (push && !pop && count == CNT_W'(DEPTH - 1)) state_n = FULL;
      FULL: if (pop && !push) state_n = FILL;
      default: state_n = FILL;
    endcase
  end

  // Samples arriving while full are ignored rather than dropped, so they are not counted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= FILL;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      if (!accept && !full && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  piece_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .resetn        (resetn),
    .push          (push),
    .pop           (pop),
    .din           (rand_id),
    .count         (count),
    .head          (piece_id),
    .head_valid    (piece_valid),
    .preview       (preview_id),
    .preview_valid (preview_valid)
  );
endmodule

// File: tb/tb_piece_queue.sv
// tb/tb_piece_queue.sv - scoreboard bench for piece_queue against a queue-based model
module tb_piece_queue;
  localparam int DEPTH = 4;

  typedef struct {
    int pid;
    int pv;
    int prv;
    int prvv;
    int drop;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] rand_id = 3'd0;
  logic       take = 1'b0;
  logic [2:0] piece_id, preview_id;
  logic       piece_valid, preview_valid;
  logic [7:0] drop_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  int   mq[$];
  int   m_drop = 0;
  int   m_last = 0;
  bit   m_last_v = 1'b0;

  piece_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .rand_id       (rand_id),
    .take          (take),
    .piece_id      (piece_id),
    .piece_valid   (piece_valid),
    .preview_id    (preview_id),
    .preview_valid (preview_valid),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference behaviour: a plain queue of shapes following the acceptance rules.
  task automatic model_step(input bit r, input int rid, input bit tk);
    bit full, pop, acc, push;
    exp_t e;
    if (!r) begin
      mq.delete();
      m_drop   = 0;
      m_last_v = 1'b0;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = tk && (mq.size() > 0);
      acc  = (rid != 7);
`ifdef PIECE_NO_REPEAT_EN
      if (m_last_v && rid == m_last) acc = 1'b0;
`endif
      push = acc && (!full || pop);
      if (!acc && !full && m_drop < 255) m_drop++;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(rid);
        m_last   = rid;
        m_last_v = 1'b1;
      end
    end
    e.pv   = (mq.size() > 0);
    e.pid  = e.pv ? mq[0] : 0;
    e.prvv = (mq.size() > 1);
    e.prv  = e.prvv ? mq[1] : 0;
    e.drop = m_drop;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit r, input int rid, input bit tk);
    @(negedge clk);
    resetn  = r;
    rand_id = 3'(rid);
    take    = tk;
    model_step(r, rid, tk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("piece_valid", int'(piece_valid), e.pv);
        check("piece_id", int'(piece_id), e.pid);
        check("preview_valid", int'(preview_valid), e.prvv);
        check("preview_id", int'(preview_id), e.prv);
        check("drop_cnt", int'(drop_cnt), e.drop);
      end
    end
  end

  initial begin : stim
    int fill_seq[6] = '{3, 7, 5, 1, 6, 2};
    cyc(0, 0, 0);
    cyc(0, 7, 1);
    foreach (fill_seq[i]) cyc(1, fill_seq[i], 0);
    cyc(1, 4, 1);
    for (int i = 0; i < 5; i++) cyc(1, 7, 1);
    for (int i = 0; i < 3; i++) cyc(1, 7, 1);
    for (int i = 0; i < 12; i++) cyc(1, i % 7, (i % 3) != 0);
    for (int i = 0; i < 10; i++) cyc(1, (i + 2) % 7, 1);
    for (int i = 0; i < 5; i++) cyc(1, i + 1, 0);
    cyc(0, 3, 1);
    cyc(1, 3, 0);
    cyc(1, 5, 0);
    cyc(0, 0, 0);
    cyc(1, 2, 0);
    cyc(1, 2, 0);
    cyc(1, 2, 0);
    cyc(1, 4, 0);
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 63) != 0), $urandom_range(0, 7), ($urandom_range(0, 2) == 0));
    for (int i = 0; i < 270; i++) cyc(1, 7, 0);
    cyc(1, 7, 0);
    @(posedge clk);
    #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/piece_queue.md
PIECE_QUEUE -- requirements
Module: piece_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of queued pieces, legal range 2..8.
REQ-002 SHALL have port clk, input, 1: single clock; all logic updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port rand_id, input, 3: raw value from the random shape source, sampled every cycle.
REQ-005 SHALL have port take, input, 1: consumer pops the head piece this cycle.
REQ-006 SHALL have port piece_id, output, 3: head shape, 0..6.
REQ-007 SHALL have port piece_valid, output, 1: piece_id holds a queued piece.
REQ-008 SHALL have port preview_id, output, 3: second entry (next-up preview).
REQ-009 SHALL have port preview_valid, output, 1: preview_id is meaningful (count >= 2).
REQ-010 SHALL have port drop_cnt, output, 8: number of rejected rand_id samples, saturating.

Function
REQ-011 SHALL implement a circular buffer of DEPTH 3-bit entries with read pointer, write pointer and count (0..DEPTH).
REQ-012 SHALL accept rand_id as valid only if rand_id != 7 and it is not excluded by REQ-024.
REQ-013 SHALL push a valid rand_id when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-014 SHALL pop when take && piece_valid; take while piece_valid == 0 SHALL be ignored with no state change.
REQ-015 SHALL, on simultaneous push and pop, leave count unchanged, advance both pointers, and write the new entry at the old write pointer.
REQ-016 SHALL wrap both pointers from DEPTH-1 to 0.
REQ-017 SHALL have registered outputs: a push into an empty queue raises piece_valid on the next cycle, with piece_id equal to the pushed value.
REQ-018 SHALL, after a pop, present the former preview entry on piece_id in the next cycle.
REQ-019 SHALL drive piece_id and preview_id to 0 whenever their valid flag is 0.
REQ-020 SHALL increment drop_cnt by 1 for each rejected sample while the queue is not full, saturating at 255; samples ignored because the queue is full SHALL NOT count.
REQ-021 SHALL implement a two-state FSM:
- FILL (count < DEPTH) goes to FULL when a push brings count to DEPTH without a pop.
- FULL goes to FILL on a pop without a push.

Reset
REQ-022 SHALL, when resetn == 0 at a rising clk edge, clear:
- pointers, count, drop_cnt;
- piece_id = 0, preview_id = 0, piece_valid = 0, preview_valid = 0;
- state = FILL.
REQ-023 SHALL let reset asserted mid-operation discard all queued entries, give take no effect during reset, and accept no push in the reset cycle.

Configuration
REQ-024 SHALL, with macro PIECE_NO_REPEAT_EN defined, also reject rand_id equal to the most recently pushed value; the record of that value is cleared by reset so the first sample is never excluded. Such rejects count in drop_cnt.
REQ-025 SHALL, without PIECE_NO_REPEAT_EN, reject only the value 7, with no last-pushed register synthesised.

Structure
REQ-026 SHALL place the following in shared package tetris_pkg:
- SHAPE_W = 3;
- SHAPE_INVALID = 3'd7;
- the shape_t typedef;
- the FSM state enum.
REQ-027 SHALL keep the buffer storage and pointer logic in one sub-module, piece_fifo; filtering, FSM and counters stay in piece_queue.

Verification
REQ-028 SHALL cover reset then fill: rand_id sequence 3,7,5,1,6,2 -> queue holds 3,5,1,6, piece_id = 3, preview_id = 5, drop_cnt = 1, 2 ignored while full, state FULL.
REQ-029 SHALL cover take on a full queue with rand_id = 4 -> next cycle piece_id = 5, queue 5,1,6,4, count stays 4.
REQ-030 SHALL cover take with an empty queue and rand_id = 7 held -> piece_valid stays 0, pointers unchanged, drop_cnt increments each cycle.
REQ-031 SHALL cover wrap-around: 10 pops interleaved with valid pushes -> the FIFO order of outputs matches input order across pointer wrap.
REQ-032 SHALL cover PIECE_NO_REPEAT_EN defined with rand_id 2,2,2,4 -> only 2 and 4 are queued, drop_cnt = 2; with the macro undefined, three 2s and one 4 are queued.
REQ-033 SHALL cover resetn low for one cycle with a full queue -> all outputs 0 the next cycle, and refill resumes in the following cycle.
